// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter request frontend.
// Requester count default, index type and FIFO count width helper.
package arb_pkg;

  localparam int NUM_DEF = 3;

  typedef logic [$clog2(NUM_DEF)-1:0] idx_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Single requester FIFO: push/pop, occupancy count and full flag.
// Head entry is always visible on rdata.
module arb_req_fifo
  import arb_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          wdata,
  output logic [DW-1:0]          rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULLV = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULLV);
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push && !rst)
      mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push)
        wptr <= wptr + 1'b1;
      if (do_pop)
        rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/arb_req_frontend.sv
// Per-requester buffering ahead of the round-robin arbiter.
// Define ARB_FE_ERR_EN to add the sticky illegal-grant flag err.
module arb_req_frontend
  import arb_pkg::*;
#(
  parameter int NUM   = NUM_DEF,
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM-1:0]          in_valid,
  output logic [NUM-1:0]          in_ready,
  input  logic [NUM*DW-1:0]       in_data,
  output logic [NUM-1:0]          bid,
  input  logic [NUM-1:0]          win,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DW-1:0]           out_data,
  output logic [$clog2(NUM)-1:0]  out_src
`ifdef ARB_FE_ERR_EN
  ,
  output logic                    err
`endif
);

  localparam int CW = cnt_w(DEPTH);
  localparam int SW = $clog2(NUM);

  logic [CW-1:0]  cnt  [NUM];
  logic [DW-1:0]  head [NUM];
  logic [NUM-1:0] full;
  logic [NUM-1:0] push;
  logic [NUM-1:0] pop;
  logic           can_load;
  logic           gnt_any;
  logic [SW-1:0]  gnt_idx;

  assign can_load = !out_valid || out_ready;

  for (genvar i = 0; i < NUM; i++) begin : g_fifo
    assign in_ready[i] = !full[i] && !rst;
    assign push[i]     = in_valid[i] && in_ready[i];
    assign bid[i]      = (cnt[i] != '0) && can_load && !rst;

    arb_req_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (in_data[i*DW +: DW]),
      .rdata (head[i]),
      .count (cnt[i]),
      .full  (full[i])
    );
  end

  // Only the lowest-index win bit backed by a bid is honoured.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    pop     = '0;
    for (int i = 0; i < NUM; i++) begin
      if (!gnt_any && win[i] && bid[i]) begin
        gnt_any = 1'b1;
        gnt_idx = SW'(i);
        pop[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (can_load) begin
      out_valid <= gnt_any;
      if (gnt_any) begin
        out_data <= head[gnt_idx];
        out_src  <= gnt_idx;
      end
    end
  end

`ifdef ARB_FE_ERR_EN
  logic illegal;

  assign illegal = !$onehot0(win) || ((win & ~bid) != '0);

  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if (illegal)
      err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_arb_req_frontend.sv
// Bench for arb_req_frontend: queue model, per-cycle compare, directed tests.
// Build with ARB_FE_ERR_EN to also check the err flag.
module tb_arb_req_frontend;

  localparam int NUM   = 3;
  localparam int DEPTH = 4;
  localparam int DW    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM-1:0]    in_valid = '0;
  logic [NUM-1:0]    in_ready;
  logic [DW-1:0]     idat [NUM];
  logic [NUM*DW-1:0] in_data;
  logic [NUM-1:0]    bid;
  logic [NUM-1:0]    win = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_src;
`ifdef ARB_FE_ERR_EN
  logic              err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int i = 0; i < NUM; i++)
      in_data[i*DW +: DW] = idat[i];
  end

  arb_req_frontend #(
    .NUM   (NUM),
    .DEPTH (DEPTH),
    .DW    (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .bid       (bid),
    .win       (win),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
`ifdef ARB_FE_ERR_EN
    ,
    .err       (err)
`endif
  );

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  // Model: one queue per requester plus the output register contents.
  logic [DW-1:0] q [NUM][$];
  logic          m_ov  = 1'b0;
  logic [DW-1:0] m_od  = '0;
  int            m_os  = 0;
  logic          m_err = 1'b0;
  bit            started = 1'b0;

  function automatic logic [NUM-1:0] m_rdy();
    logic [NUM-1:0] r;
    for (int i = 0; i < NUM; i++)
      r[i] = !rst && (q[i].size() < DEPTH);
    return r;
  endfunction

  function automatic logic [NUM-1:0] m_bid();
    logic [NUM-1:0] b;
    for (int i = 0; i < NUM; i++)
      b[i] = !rst && (q[i].size() != 0) && (!m_ov || out_ready);
    return b;
  endfunction

  always @(posedge clk) begin
    logic [NUM-1:0] b;
    logic [NUM-1:0] r;
    int g;
    b = m_bid();
    r = m_rdy();
    g = -1;
    if (rst) begin
      for (int i = 0; i < NUM; i++) q[i].delete();
      m_ov  = 1'b0;
      m_od  = '0;
      m_os  = 0;
      m_err = 1'b0;
    end else begin
      for (int i = 0; i < NUM; i++)
        if (g < 0 && win[i] && b[i]) g = i;
      if ($countones(win) > 1 || (win & ~b) != '0) m_err = 1'b1;
      if (!m_ov || out_ready) begin
        if (g >= 0) begin
          m_od = q[g].pop_front();
          m_os = g;
          m_ov = 1'b1;
        end else begin
          m_ov = 1'b0;
        end
      end
      for (int i = 0; i < NUM; i++)
        if (in_valid[i] && r[i]) q[i].push_back(idat[i]);
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, m_rdy());
      chk("bid", bid, m_bid());
      chk("out_valid", out_valid, m_ov);
      if (m_ov) begin
        chk("out_data", out_data, m_od);
        chk("out_src", out_src, m_os);
      end
`ifdef ARB_FE_ERR_EN
      chk("err", err, m_err);
`endif
    end
  end

  // Arbiter mock: 0 none, 1 fixed priority, 2 round robin, 3 forced.
  int             mode   = 0;
  int             rr     = 0;
  logic [NUM-1:0] wforce = '0;

  task automatic setwin();
    logic [NUM-1:0] b;
    int idx;
    b   = m_bid();
    win = '0;
    case (mode)
      1: for (int i = 0; i < NUM; i++)
           if (b[i] && win == '0) win[i] = 1'b1;
      2: for (int k = 0; k < NUM; k++) begin
           idx = (rr + k) % NUM;
           if (b[idx] && win == '0) begin
             win[idx] = 1'b1;
             rr = (idx + 1) % NUM;
           end
         end
      3: win = wforce;
      default: ;
    endcase
  endtask

  task automatic tick();
    setwin();
    @(posedge clk);
    #1;
    in_valid = '0;
  endtask

  logic [DW-1:0] capd [$];
  int            caps [$];

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      if (out_valid) begin
        capd.push_back(out_data);
        caps.push_back(int'(out_src));
      end
    end
  endtask

  logic [DW-1:0] exp_d [6];
  int            exp_s [6];

  initial begin
    for (int i = 0; i < NUM; i++) idat[i] = '0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", in_ready, 3'b000);
    chk("rst_bid", bid, 3'b000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_src", out_src, 2'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 3'b111);

    // Single push latency
    mode      = 1;
    out_ready = 1'b1;
    in_valid  = 3'b010;
    idat[1]   = 8'hA5;
    tick();
    chk("sp_bid", bid, 3'b010);
    tick();
    chk("sp_valid", out_valid, 1'b1);
    chk("sp_data", out_data, 8'hA5);
    chk("sp_src", out_src, 2'd1);
    tick();
    chk("sp_idle", out_valid, 1'b0);

    // Fill requester 0, fifth push refused
    mode = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 3'b001;
      idat[0]  = 8'h10 + 8'(k);
      tick();
    end
    chk("fill_ready0", in_ready[0], 1'b0);
    in_valid = 3'b001;
    idat[0]  = 8'h14;
    tick();
    chk("fill_ready0_hold", in_ready[0], 1'b0);
    mode = 1;
    capd.delete();
    caps.delete();
    drain(6);
    chk("fill_drain_n", capd.size(), 4);
    for (int k = 0; k < capd.size() && k < 4; k++)
      chk("fill_drain_data", capd[k], 8'h10 + 8'(k));

    // Stall
    mode     = 0;
    in_valid = 3'b101;
    idat[0]  = 8'h30;
    idat[2]  = 8'h20;
    tick();
    in_valid = 3'b100;
    idat[2]  = 8'h21;
    tick();
    mode      = 1;
    out_ready = 1'b0;
    tick();
    chk("stall_valid", out_valid, 1'b1);
    chk("stall_src", out_src, 2'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_bid", bid, 3'b000);
      chk("stall_data", out_data, 8'h30);
      chk("stall_valid_hold", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    capd.delete();
    caps.delete();
    drain(4);
    chk("stall_drain_n", capd.size(), 2);
    if (capd.size() == 2) begin
      chk("stall_drain_d0", capd[0], 8'h20);
      chk("stall_drain_d1", capd[1], 8'h21);
    end

    // Round-robin flow
    mode = 0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 3'b111;
      idat[0]  = 8'h40 + 8'(k);
      idat[1]  = 8'h50 + 8'(k);
      idat[2]  = 8'h60 + 8'(k);
      tick();
    end
    exp_d = '{8'h40, 8'h50, 8'h60, 8'h41, 8'h51, 8'h61};
    exp_s = '{0, 1, 2, 0, 1, 2};
    mode  = 2;
    rr    = 0;
    capd.delete();
    caps.delete();
    drain(8);
    chk("rr_n", capd.size(), 6);
    for (int k = 0; k < capd.size() && k < 6; k++) begin
      chk("rr_src", caps[k], exp_s[k]);
      chk("rr_data", capd[k], exp_d[k]);
    end

    // Illegal win
    mode     = 0;
    in_valid = 3'b011;
    idat[0]  = 8'h70;
    idat[1]  = 8'h71;
    tick();
    chk("ill_bid", bid, 3'b011);
    mode   = 3;
    wforce = 3'b110;
    tick();
    mode = 0;
    chk("ill_valid", out_valid, 1'b1);
    chk("ill_data", out_data, 8'h71);
    chk("ill_src", out_src, 2'd1);
    chk("ill_bid_after", bid, 3'b001);
`ifdef ARB_FE_ERR_EN
    chk("ill_err", err, 1'b1);
`endif
    tick();
    tick();
`ifdef ARB_FE_ERR_EN
    chk("ill_err_sticky", err, 1'b1);
`endif
    mode = 1;
    capd.delete();
    caps.delete();
    drain(3);
    chk("ill_drain_n", capd.size(), 1);
    if (capd.size() == 1)
      chk("ill_drain_d", capd[0], 8'h70);

    // Mid-operation reset with full FIFOs and a held output
    mode = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 3'b111;
      idat[0]  = 8'h80 + 8'(k);
      idat[1]  = 8'h90 + 8'(k);
      idat[2]  = 8'hA0 + 8'(k);
      tick();
    end
    chk("mr_full", in_ready, 3'b000);
    mode      = 1;
    out_ready = 1'b0;
    tick();
    mode     = 0;
    in_valid = 3'b001;
    idat[0]  = 8'h84;
    tick();
    chk("mr_pre_ready", in_ready, 3'b000);
    chk("mr_pre_valid", out_valid, 1'b1);
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 3'b111;
    #1;
    chk("mr_rst_ready", in_ready, 3'b000);
    chk("mr_rst_bid", bid, 3'b000);
    tick();
    rst = 1'b0;
    #1;
    chk("mr_ready", in_ready, 3'b111);
    chk("mr_valid", out_valid, 1'b0);
    chk("mr_bid", bid, 3'b000);
`ifdef ARB_FE_ERR_EN
    chk("mr_err", err, 1'b0);
`endif
    mode = 1;
    tick();
    chk("mr_empty_bid", bid, 3'b000);
    chk("mr_empty_valid", out_valid, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arb_req_frontend.md
# arb_req_frontend

Per-requester buffering stage that sits directly upstream of the round-robin arbiter. Each of NUM requesters pushes payloads into its own small FIFO. The block drives the arbiter's bid vector from FIFO occupancy and consumes the arbiter's one-hot win vector. It pops the granted FIFO into a single registered output stage with a valid/ready handshake toward the downstream consumer.

## Interface
- NUM, 3: number of requesters; equals the arbiter's requester count.
- DEPTH, 4: entries per requester FIFO; power of two, ≥2.
- DW, 8: payload width in bits.

- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  NUM  per-requester push request.
- in_ready  output  NUM  per-requester FIFO not full.
- in_data  input  NUM×DW  per-requester payload, packed, requester i at bits [i*DW +: DW].
- bid  output  NUM  to arbiter; bit i = requester i has a head entry eligible for grant.
- win  input  NUM  from arbiter; one-hot or zero, combinational function of bid in the same cycle.
- out_valid  output  1  output register holds a granted payload.
- out_ready  input  1  downstream accepts.
- out_data  output  DW  granted payload.
- out_src  output  $clog2(NUM)  index of the requester that supplied out_data.
- err  output  1  sticky illegal-grant flag; present only with ARB_FE_ERR_EN.

## Operation
- Push: in_valid[i] && in_ready[i] writes in_data[i] to FIFO i.
- in_ready[i] = (count[i] != DEPTH) && !rst.
- Bid gating: bid[i] = (count[i] != 0) && can_load. can_load = !out_valid || out_ready. bid depends only on registered state and out_ready.
- Grant: win[i] && bid[i] pops FIFO i. The head is loaded into out_data, i is loaded into out_src, and out_valid is set next cycle.
- No grant while can_load: out_valid clears if out_ready.
- Illegal win, either multi-hot or a win bit where bid=0: only the lowest-index bit with bid=1 is honoured. Other bits are ignored, with no pop and no data change.
- Push and pop on the same FIFO in the same cycle: count unchanged, both take effect. At full this cannot occur, because in_ready=0.
- FIFO pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Output register holds data stable while out_valid && !out_ready.

## Timing
- Reset values: all counts 0, pointers 0, out_valid 0, out_data 0, out_src 0, bid 0, in_ready 0 during rst (1 the cycle after), err 0.
- rst asserted mid-operation: all FIFO contents and any held output are discarded; no handshake completes in the rst cycle.
- Latency, empty system: push accepted at cycle t → bid[i]=1 at t+1 → with win[i] at t+1, out_valid=1 at t+2.
- Back-to-back: with out_ready held 1, one grant per cycle, sustained throughput 1 payload/cycle.
- Stall: out_valid && !out_ready forces bid=0. The arbiter sees no bids and no pops occur.

## Configuration
- ARB_FE_ERR_EN defined: err sets on any cycle with win multi-hot, or win[i]=1 with bid[i]=0. err clears only on rst.
- Not defined: no err port, no checking logic; illegal-win handling per Operation still applies.

## Structure
- Shared package arb_pkg: NUM default, index typedef (logic [$clog2(NUM)-1:0]), and count width function.
- One sub-module, arb_req_fifo (DW, DEPTH): single FIFO with push/pop, count, full/empty. It is instantiated NUM times via generate.
- Top level holds bid gating, grant decode, output register, and the optional err logic.

## Test plan
- Single push: rst, then requester 1 pushes 0xA5 at t with out_ready=1, win mirrors bid → bid=3'b010 at t+1, out_valid=1, out_data=0xA5, out_src=1 at t+2.
- Fill: push 4 entries to requester 0 with no win → in_ready[0]=0 after the 4th, and a 5th push is not accepted. Counts stay at 4.
- Stall: out_valid=1, out_ready=0 for 3 cycles → bid=0 throughout, out_data stable, FIFO counts unchanged.
- Round-robin flow: all 3 FIFOs hold 2 entries, arbiter model rotates 0,1,2,0,1,2 → out_src sequence 0,1,2,0,1,2, with each FIFO's entries in push order.
- Illegal win (ARB_FE_ERR_EN): bid=3'b011, win=3'b110 → FIFO 1 pops, FIFO 2 untouched, err=1 and stays 1 until rst.
- Mid-operation reset: rst for 1 cycle with full FIFOs and out_valid=1 → next cycle all counts 0, out_valid=0, bid=0, in_ready=3'b111.
